// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t         state, state_next;
    logic [CW-1:0]  cnt;
    logic           accept;
    logic           calc_last;

    // Operand capture: op[0]=0 selects the signed variant, op[1]=1 selects divide.
    logic             is_div, is_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    logic [WIDTH-1:0] hi_acc, lo_acc, m_reg, a_raw;
    logic             is_div_r, neg_q_r, neg_r_r, div0_r;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign accept    = start && !busy;
    assign calc_last = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = CALC;
            CALC: begin
                busy = 1'b1;
                if (calc_last) state_next = FIX;
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? CALC : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        is_div    = op[1];
        is_signed = ~op[0];
        a_neg     = is_signed & SrcA[WIDTH-1];
        b_neg     = is_signed & SrcB[WIDTH-1];
        a_mag     = a_neg ? -SrcA : SrcA;
        b_mag     = b_neg ? -SrcB : SrcB;
    end

    always_comb begin
        mul_sum   = {1'b0, hi_acc} + {1'b0, (lo_acc[0] ? m_reg : '0)};
        div_shift = {hi_acc, lo_acc[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, m_reg});
        div_diff  = div_shift[WIDTH-1:0] - m_reg;
        prod      = {hi_acc, lo_acc};
        prod_fix  = neg_q_r ? -prod : prod;
        quo_fix   = neg_q_r ? -lo_acc : lo_acc;
        rem_fix   = neg_r_r ? -hi_acc : hi_acc;
    end

    // lo_acc holds the multiplier (shifting out) or the dividend/quotient (shifting through).
    // The final CALC cycle (cnt==LAST) does no iteration; it sets the fixed latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            hi_acc   <= '0;
            lo_acc   <= '0;
            m_reg    <= '0;
            a_raw    <= '0;
            is_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            div0_r   <= 1'b0;
        end else if (accept) begin
            cnt      <= '0;
            hi_acc   <= '0;
            lo_acc   <= is_div ? a_mag : b_mag;
            m_reg    <= is_div ? b_mag : a_mag;
            a_raw    <= SrcA;
            is_div_r <= is_div;
            neg_q_r  <= a_neg ^ b_neg;
            neg_r_r  <= a_neg;
            div0_r   <= is_div && (SrcB == '0);
        end else if (state == CALC && !calc_last) begin
            cnt <= cnt + CW'(1);
            if (is_div_r) begin
                if (div_ge) begin
                    hi_acc <= div_diff;
                    lo_acc <= {lo_acc[WIDTH-2:0], 1'b1};
                end else begin
                    hi_acc <= div_shift[WIDTH-1:0];
                    lo_acc <= {lo_acc[WIDTH-2:0], 1'b0};
                end
            end else begin
                hi_acc <= mul_sum[WIDTH:1];
                lo_acc <= {mul_sum[0], lo_acc[WIDTH-1:1]};
            end
        end
    end

    // FIX result wins; mthi/mtlo only land while the unit is not busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (state == FIX) begin
            if (!is_div_r) begin
                hi <= prod_fix[2*WIDTH-1:WIDTH];
                lo <= prod_fix[WIDTH-1:0];
            end else if (div0_r) begin
                hi <= a_raw;
                lo <= '1;
            end else begin
                hi <= rem_fix;
                lo <= quo_fix;
            end
        end else if (!busy) begin
            if (mthi) hi <= SrcA;
            if (mtlo) lo <= SrcA;
        end
    end

endmodule
